// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C front-end blocks.
package i2c_pkg;

    // Button conditioner FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        PRESSED   = 2'd2,
        REL_CHK   = 2'd3
    } key_state_t;

    // 10 ms at 50 MHz; simulation benches override with small values
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int DEBOUNCE_CNT_W_DEFAULT  = 19;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for asynchronous board inputs.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; reset loads the idle level of the pin
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2c_key_cond.sv
// Push-button conditioner: synchronise, debounce and turn each accepted
// press into a single-cycle strobe for the I2C transmitter.
module i2c_key_cond
    import i2c_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = DEBOUNCE_CNT_W_DEFAULT,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_pulse,
    output logic key_release,
    output logic key_level
);

    localparam logic             SYNC_RESET = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_sync;
    logic             p;
    key_state_t       state;
    key_state_t       next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             pulse_d;
    logic             release_d;
    logic             level_d;

    sync2 #(
        .RESET_VAL (SYNC_RESET)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key_raw),
        .q     (key_sync)
    );

    assign p = KEY_ACTIVE_LOW ? ~key_sync : key_sync;

    // State, counter and registered strobe/level outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            key_pulse   <= 1'b0;
            key_release <= 1'b0;
            key_level   <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            key_pulse   <= pulse_d;
            key_release <= release_d;
            key_level   <= level_d;
        end
    end

    // Next-state logic: a level must hold for DEBOUNCE_CYCLES checks after
    // entering a CHK state; any reversal falls back without a strobe
    always_comb begin
        next_state = state;
        next_cnt   = '0;
        pulse_d    = 1'b0;
        release_d  = 1'b0;
        case (state)
            IDLE: begin
                if (p) begin
                    next_state = PRESS_CHK;
                end
            end
            PRESS_CHK: begin
                if (!p) begin
                    next_state = IDLE;
                end else if (cnt == CNT_LAST) begin
                    next_state = PRESSED;
                    pulse_d    = 1'b1;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!p) begin
                    next_state = REL_CHK;
                end
            end
            REL_CHK: begin
                if (p) begin
                    next_state = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    next_state = IDLE;
                    release_d  = 1'b1;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        level_d = (next_state == PRESSED) || (next_state == REL_CHK);
    end

endmodule
